// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-side access unit between the MIPS EX/MEM stage and a word-addressed
//   data memory that reads and writes only full 32-bit words. Handles byte,
//   halfword and word loads/stores, uses read-modify-write for sub-word
//   stores, extends load data, and rejects misaligned or illegal-size
//   requests without issuing any memory strobe.
//
//   Optional build macro LSU_STATS_EN adds saturating 16-bit counters of
//   completed loads, stores and errors (stat_loads, stat_stores, stat_errs).
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_write, req_size        1 = store; size 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned               zero-extend sub-word loads when set
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data (0 for stores/errors), error flag
//   mem_addr, mem_wdata        word-aligned address and write word to memory
//   mem_read, mem_write        memory strobes (never both high)
//   mem_rdata                  word returned by memory
//   stat_*                     (LSU_STATS_EN only) completion counters
module load_store_unit #(
  parameter int unsigned BIG_ENDIAN = 1,
  parameter int unsigned READ_WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int unsigned CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_WAIT - 1);

  logic [2:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    addr_off;
  logic [1:0]    size_q;
  logic          write_q;
  logic          unsigned_q;
  logic [31:0]   wdata_q;

  logic          req_bad;
  logic [1:0]    byte_lane;
  logic          half_lane;
  logic [7:0]    byte_val;
  logic [15:0]   half_val;
  logic [31:0]   load_ext;
  logic [31:0]   merged;

  // Control outputs are pure state decodes, so no request input can reach
  // the memory strobes combinationally.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_read   = (state == S_RD);
  assign mem_write  = (state == S_WR);

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  // Physical lane of the addressed byte/half inside the 32-bit word; for the
  // big-endian order byte offset k sits in lane 3-k, i.e. the inverted offset.
  always_comb begin
    byte_lane = (BIG_ENDIAN != 0) ? ~addr_off : addr_off;
    half_lane = (BIG_ENDIAN != 0) ? ~addr_off[1] : addr_off[1];
    byte_val  = mem_rdata[{byte_lane, 3'b000} +: 8];
    half_val  = mem_rdata[{half_lane, 4'b0000} +: 16];
  end

  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'h000000, byte_val}
                                     : {{24{byte_val[7]}}, byte_val};
      2'b01:   load_ext = unsigned_q ? {16'h0000, half_val}
                                     : {{16{half_val[15]}}, half_val};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    case (size_q)
      2'b00:   merged[{byte_lane, 3'b000} +: 8]   = wdata_q[7:0];
      2'b01:   merged[{half_lane, 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      addr_off   <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_off   <= req_addr[1:0];
            size_q     <= req_size;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_bad;
            if (req_bad) begin
              state <= S_RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_write && (req_size == 2'b10)) begin
                mem_wdata <= req_wdata;
                state     <= S_WR;
              end else begin
                wait_cnt <= WAIT_LOAD;
                state    <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (wait_cnt == '0) state <= S_CAP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_CAP: begin
          // mem_wdata doubles as the word buffer for read-modify-write.
          if (write_q) begin
            mem_wdata <= merged;
            state     <= S_WR;
          end else begin
            resp_rdata <= load_ext;
            state      <= S_RESP;
          end
        end
        S_WR: state <= S_RESP;
        S_RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == S_RESP) begin
      if (resp_err)     stat_errs   <= sat_inc(stat_errs);
      else if (write_q) stat_stores <= sat_inc(stat_stores);
      else              stat_loads  <= sat_inc(stat_loads);
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (BIG_ENDIAN=1, READ_WAIT=1) with a
// small synchronous word memory attached to the memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.BIG_ENDIAN(1), .READ_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // Synchronous memory: data read on the mem_read edge is presented the next
  // cycle; a backdoor port preloads words.
  logic [31:0] mem [0:15];
  logic [31:0] rdata_q;
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_read) rdata_q <= mem[mem_addr[5:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          mem_idx;     // -1: no memory word check
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];
  int exp_loads = 0, exp_stores = 0, exp_errs = 0;

  task automatic run_vec(input vec_t v);
    int lat, rd_cycles, wr_cycles, both, ready_busy;
    logic [31:0] got_rdata, strobe_addr;
    logic got_err;
    lat = 0; rd_cycles = 0; wr_cycles = 0; both = 0; ready_busy = 0;
    got_rdata = 32'hX; got_err = 1'bx; strobe_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    check({v.name, "/ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size;
    req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_read && mem_write) both++;
      if (mem_read || mem_write) begin
        if (mem_addr !== {v.addr[31:2], 2'b00}) strobe_addr = mem_addr;
      end
      if (mem_read) rd_cycles++;
      if (mem_write) wr_cycles++;
      if (req_ready) ready_busy++;
      if (resp_valid) begin
        lat = c; got_rdata = resp_rdata; got_err = resp_err;
        break;
      end
    end
    check({v.name, "/latency"}, lat, v.exp_lat);
    check({v.name, "/rdata"}, got_rdata, v.exp_rdata);
    check({v.name, "/err"}, {31'd0, got_err}, {31'd0, v.exp_err});
    check({v.name, "/mem_read_cycles"}, rd_cycles, v.exp_rd);
    check({v.name, "/mem_write_cycles"}, wr_cycles, v.exp_wr);
    check({v.name, "/strobe_overlap"}, both, 0);
    check({v.name, "/busy_ready"}, ready_busy, 0);
    check({v.name, "/mem_addr"}, strobe_addr, {v.addr[31:2], 2'b00});
    if (v.mem_idx >= 0) check({v.name, "/mem_word"}, mem[v.mem_idx], v.exp_mem);
    if (v.exp_err) exp_errs++;
    else if (v.wr) exp_stores++;
    else exp_loads++;
    @(negedge clk);
    check({v.name, "/ready_after"}, {31'd0, req_ready}, 32'd1);
    check({v.name, "/resp_drop"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/req_ready", {31'd0, req_ready}, 32'd1);
    check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst/resp_rdata", resp_rdata, 32'd0);
    check("rst/resp_err", {31'd0, resp_err}, 32'd0);
    check("rst/mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);
    check("rst/mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    poke(4'd0, 32'h11223344);
    poke(4'd1, 32'h80F0A5C3);
    poke(4'd2, 32'hAABBCCDD);
    poke(4'd4, 32'hCAFEF00D);

    //          name        wr    size   uns   addr   wdata         rdata         err  lat rd wr idx exp_mem
    vecs.push_back('{"lb1",  1'b0, 2'b00, 1'b0, 32'h1, 32'h0,        32'h00000022, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"lh6s", 1'b0, 2'b01, 1'b0, 32'h6, 32'h0,        32'hFFFFA5C3, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"lh6u", 1'b0, 2'b01, 1'b1, 32'h6, 32'h0,        32'h0000A5C3, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"lb4s", 1'b0, 2'b00, 1'b0, 32'h4, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"lb7u", 1'b0, 2'b00, 1'b1, 32'h7, 32'h0,        32'h000000C3, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"lh4s", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0,        32'hFFFF80F0, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"lw0u", 1'b0, 2'b10, 1'b1, 32'h0, 32'h0,        32'h11223344, 1'b0, 3, 1, 0, -1, 32'h0});
    vecs.push_back('{"sbA",  1'b1, 2'b00, 1'b0, 32'hA, 32'hFFFFFF5E, 32'h00000000, 1'b0, 4, 1, 1,  2, 32'hAABB5EDD});
    vecs.push_back('{"sb8",  1'b1, 2'b00, 1'b0, 32'h8, 32'h00000077, 32'h00000000, 1'b0, 4, 1, 1,  2, 32'h77BB5EDD});
    vecs.push_back('{"swC",  1'b1, 2'b10, 1'b0, 32'hC, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1,  3, 32'hDEADBEEF});
    vecs.push_back('{"sh0",  1'b1, 2'b01, 1'b0, 32'h0, 32'hFFFF1234, 32'h00000000, 1'b0, 4, 1, 1,  0, 32'h12343344});
    vecs.push_back('{"sb3",  1'b1, 2'b00, 1'b0, 32'h3, 32'h000000AB, 32'h00000000, 1'b0, 4, 1, 1,  0, 32'h123433AB});
    vecs.push_back('{"sh6",  1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, 32'h00000000, 1'b0, 4, 1, 1,  1, 32'h80F0BEEF});
    vecs.push_back('{"lw2e", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"lh3e", 1'b0, 2'b01, 1'b0, 32'h3, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"sz3e", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"sw1e", 1'b1, 2'b10, 1'b0, 32'h1, 32'h01020304, 32'h00000000, 1'b1, 1, 0, 0,  0, 32'h123433AB});
    vecs.push_back('{"lw0",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'h123433AB, 1'b0, 3, 1, 0, -1, 32'h0});

    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef LSU_STATS_EN
    @(negedge clk);
    check("stat_loads", {16'd0, stat_loads}, exp_loads);
    check("stat_stores", {16'd0, stat_stores}, exp_stores);
    check("stat_errs", {16'd0, stat_errs}, exp_errs);
`endif

    // Reset while a sub-word store sits in CAP: the write must never issue.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h11; req_wdata = 32'h99;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstcap/rd_phase", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check("rstcap/cap_phase", {30'd0, mem_read, mem_write}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstcap/mem_write", {31'd0, mem_write}, 32'd0);
    check("rstcap/req_ready", {31'd0, req_ready}, 32'd1);
    check("rstcap/resp_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    begin
      int wr_seen;
      wr_seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (mem_write) wr_seen++;
      end
      check("rstcap/no_late_write", wr_seen, 0);
    end
    check("rstcap/mem_word", mem[4], 32'hCAFEF00D);
`ifdef LSU_STATS_EN
    check("rstcap/stat_errs_clr", {16'd0, stat_errs}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
